// File: rtl/image_dram_read_scheduler.sv
// Splits one {end_addr, start_addr} image descriptor into DRAM read bursts of at most
// MAX_BURST_LEN beats that never cross a BOUNDARY_BYTES boundary, one burst outstanding at a time.
module image_dram_read_scheduler #(
  parameter int unsigned DRAM_ADDR_WIDTH = 39,
  parameter int unsigned DRAM_DATA_WIDTH = 128,
  parameter int unsigned MAX_BURST_LEN   = 256,
  parameter int unsigned BOUNDARY_BYTES  = 4096
) (
  input  logic                       clk_pixel,
  input  logic                       image_sender_reset,
  input  logic                       start,
  input  logic [63:0]                start_addr,
  input  logic [63:0]                end_addr,
  input  logic                       abort,
  input  logic                       dram_read_busy,
  input  logic                       buffer_full,
  input  logic                       dram_read_data_valid,
  output logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
  output logic [7:0]                 dram_read_len,
  output logic                       dram_read_en,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  localparam int unsigned BEAT_BYTES = DRAM_DATA_WIDTH / 8;
  localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam int unsigned BND_SHIFT  = $clog2(BOUNDARY_BYTES);
  localparam int unsigned BND_RW     = BND_SHIFT + 1;
  localparam int unsigned BND_BEATS  = BOUNDARY_BYTES / BEAT_BYTES;
  localparam int unsigned CNT_MAX    = (MAX_BURST_LEN > BND_BEATS) ? MAX_BURST_LEN : BND_BEATS;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
  // One extra bit so a transfer spanning the whole address space still fits.
  localparam int unsigned REM_W      = DRAM_ADDR_WIDTH - BEAT_SHIFT + 1;
  localparam logic [63:0] ADDR_LIMIT = 64'(1) << DRAM_ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_BEATS = 3'd2,
    S_DONE       = 3'd3,
    S_DRAIN      = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [DRAM_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [REM_W-1:0]           rem_q, rem_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  logic [DRAM_ADDR_WIDTH-1:0] addr_d;
  logic [7:0]                 len_d;
  logic                       en_d, busy_d, done_d, error_d;

  logic                       desc_err;
  logic [REM_W-1:0]           rem_init;
  logic [BND_RW-1:0]          bnd_room;
  logic [CNT_W-1:0]           beats;
  logic [CNT_W-1:0]           cnt_after;
  logic                       can_issue;

  // Descriptor validation and initial beat count
  always_comb begin
    desc_err = (|start_addr[BEAT_SHIFT-1:0]) || (|end_addr[BEAT_SHIFT-1:0]) ||
               (end_addr <= start_addr) || (end_addr > ADDR_LIMIT);
    rem_init = REM_W'((end_addr - start_addr) >> BEAT_SHIFT);
  end

  // Burst size: limited by remaining beats, max burst length and room to the boundary
  always_comb begin
    bnd_room = BND_RW'(BOUNDARY_BYTES) - BND_RW'(cur_addr_q[BND_SHIFT-1:0]);
    beats    = CNT_W'(bnd_room >> BEAT_SHIFT);
    if (beats > CNT_W'(MAX_BURST_LEN)) beats = CNT_W'(MAX_BURST_LEN);
    if (rem_q < REM_W'(beats))         beats = CNT_W'(rem_q);
  end

  always_comb begin
    cnt_after = cnt_q;
    if (dram_read_data_valid && (cnt_q != '0)) cnt_after = cnt_q - CNT_W'(1);
    can_issue = !dram_read_busy && !buffer_full;
  end

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    addr_d     = dram_read_addr;
    len_d      = dram_read_len;
    en_d       = 1'b0;
    done_d     = 1'b0;
    error_d    = error;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          error_d = desc_err;
          if (!desc_err) begin
            cur_addr_d = start_addr[DRAM_ADDR_WIDTH-1:0];
            rem_d      = rem_init;
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (can_issue) begin
          en_d       = 1'b1;
          addr_d     = cur_addr_q;
          len_d      = 8'(beats - CNT_W'(1));
          cur_addr_d = cur_addr_q + (DRAM_ADDR_WIDTH'(beats) << BEAT_SHIFT);
          rem_d      = rem_q - REM_W'(beats);
          cnt_d      = beats;
          state_d    = S_WAIT_BEATS;
        end
      end
      S_WAIT_BEATS: begin
        cnt_d = cnt_after;
        if (abort) begin
          state_d = (cnt_after == '0) ? S_IDLE : S_DRAIN;
        end else if (cnt_after == '0) begin
          state_d = (rem_q == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        done_d  = !abort;
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        cnt_d = cnt_after;
        if (cnt_after == '0) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_pixel) begin
    if (image_sender_reset) begin
      state_q        <= S_IDLE;
      cur_addr_q     <= '0;
      rem_q          <= '0;
      cnt_q          <= '0;
      dram_read_addr <= '0;
      dram_read_len  <= '0;
      dram_read_en   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_addr_q     <= cur_addr_d;
      rem_q          <= rem_d;
      cnt_q          <= cnt_d;
      dram_read_addr <= addr_d;
      dram_read_len  <= len_d;
      dram_read_en   <= en_d;
      busy           <= busy_d;
      done           <= done_d;
      error          <= error_d;
    end
  end

endmodule

// File: tb/tb_image_dram_read_scheduler.sv
// Randomized self-checking bench: expected bursts come from a descriptor-level burst-splitting model.
module tb_image_dram_read_scheduler;

  localparam longint unsigned LIMIT = 64'h80_0000_0000;

  logic        clk_pixel = 1'b0;
  logic        image_sender_reset;
  logic        start;
  logic [63:0] start_addr;
  logic [63:0] end_addr;
  logic        abort;
  logic        dram_read_busy;
  logic        buffer_full;
  logic        dram_read_data_valid;
  logic [38:0] dram_read_addr;
  logic [7:0]  dram_read_len;
  logic        dram_read_en;
  logic        busy;
  logic        done;
  logic        error;

  int n_cmp = 0;
  int n_err = 0;

  longint unsigned exp_a[$];
  int              exp_l[$];

  image_dram_read_scheduler dut (
    .clk_pixel            (clk_pixel),
    .image_sender_reset   (image_sender_reset),
    .start                (start),
    .start_addr           (start_addr),
    .end_addr             (end_addr),
    .abort                (abort),
    .dram_read_busy       (dram_read_busy),
    .buffer_full          (buffer_full),
    .dram_read_data_valid (dram_read_data_valid),
    .dram_read_addr       (dram_read_addr),
    .dram_read_len        (dram_read_len),
    .dram_read_en         (dram_read_en),
    .busy                 (busy),
    .done                 (done),
    .error                (error)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic clear_inputs();
    start = 1'b0; abort = 1'b0; dram_read_busy = 1'b0; buffer_full = 1'b0;
    dram_read_data_valid = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    image_sender_reset = 1'b1;
    step();
    step();
    image_sender_reset = 1'b0;
  endtask

  // Reference: split [s, e) into bursts bounded by 256 beats and 4 KB pages
  function automatic void build(input longint unsigned s, input longint unsigned e);
    longint unsigned a, rem, room, n;
    a = s;
    rem = (e - s) / 16;
    exp_a.delete();
    exp_l.delete();
    while (rem > 0) begin
      room = (4096 - (a % 4096)) / 16;
      n = rem;
      if (n > 256)  n = 256;
      if (n > room) n = room;
      exp_a.push_back(a);
      exp_l.push_back(int'(n) - 1);
      a = a + n * 16;
      rem = rem - n;
    end
  endfunction

  // mode 0: clean, 1: random stalls/gaps/stray beats/ignored starts, 2: full held, 3: busy held
  task automatic run_transfer(input longint unsigned s, input longint unsigned e,
                              input int mode, input int budget);
    int outstanding = 0;
    int last_beat = 0;
    int base = 2;
    int t;
    int n_len;
    bit fin = 0;
    bit stall_hist[$];
    build(s, e);
    for (int iter = 0; iter < budget && !fin; iter++) begin
      if (iter == 1) chk("err_clr", error, 0);
      if (dram_read_en) begin
        chk("one_burst", outstanding, 0);
        chk("strobe_expected", exp_a.size() > 0, 1);
        if (exp_a.size() > 0) begin
          n_len = exp_l.pop_front();
          chk("addr", dram_read_addr, exp_a.pop_front());
          chk("len", dram_read_len, n_len);
          t = base;
          while (t - 1 < stall_hist.size() && stall_hist[t-1]) t++;
          chk("strobe_lat", iter, t);
          chk("strobe_busy", busy, 1);
          outstanding = n_len + 1;
        end
      end
      if (done) begin
        chk("done_lat", iter, last_beat + 2);
        chk("done_left", exp_a.size() + outstanding, 0);
        chk("done_busy", busy, 0);
        chk("done_err", error, 0);
        fin = 1;
      end else begin
        start = 1'b0;
        if (iter == 0) begin
          start = 1'b1; start_addr = s; end_addr = e;
        end else if (mode == 1 && outstanding > 0 && $urandom_range(0, 15) == 0) begin
          start = 1'b1;
          start_addr = 64'($urandom_range(0, 1000)) << 4;
          if ($urandom_range(0, 1) == 1) start_addr = start_addr | 64'h8;
          end_addr = start_addr + 64'h100;
        end
        case (mode)
          1: begin
            buffer_full    = ($urandom_range(0, 3) == 0);
            dram_read_busy = ($urandom_range(0, 4) == 0);
          end
          2: begin buffer_full = (iter <= 20); dram_read_busy = 1'b0; end
          3: begin dram_read_busy = (iter <= 20); buffer_full = 1'b0; end
          default: begin buffer_full = 1'b0; dram_read_busy = 1'b0; end
        endcase
        stall_hist.push_back(buffer_full || dram_read_busy);
        dram_read_data_valid = 1'b0;
        if (outstanding > 0)
          dram_read_data_valid = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
        else if (mode == 1)
          dram_read_data_valid = ($urandom_range(0, 5) == 0);
        if (dram_read_data_valid && outstanding > 0) begin
          outstanding--;
          if (outstanding == 0) begin
            last_beat = iter;
            base = iter + 2;
          end
        end
        step();
      end
    end
    clear_inputs();
    chk("finished", fin, 1);
    if (fin) begin
      step();
      chk("done_pulse", done, 0);
    end else begin
      do_reset();
    end
  endtask

  task automatic bad_desc(input string tag, input longint unsigned s, input longint unsigned e);
    bit saw = 0;
    start = 1'b1; start_addr = s; end_addr = e;
    step();
    start = 1'b0;
    chk(tag, error, 1);
    chk({tag, "_busy"}, busy, 0);
    repeat (3) begin saw |= dram_read_en; step(); end
    saw |= dram_read_en;
    chk({tag, "_en"}, saw, 0);
  endtask

  initial begin
    int n;
    int guard;
    bit saw;
    bit busy_drop;
    longint unsigned s, e, nb;

    clear_inputs();
    start_addr = '0; end_addr = '0;
    image_sender_reset = 1'b1;
    step();
    step();
    chk("rst_en", dram_read_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    chk("rst_addr", dram_read_addr, 0);
    chk("rst_len", dram_read_len, 0);
    image_sender_reset = 1'b0;
    step();

    // Page-crossing split
    run_transfer(64'hF80, 64'h1100, 0, 500);

    // Descriptor errors, abort beating start, then a good descriptor clears error
    bad_desc("e_start_mis", 64'h1008, 64'h2000);
    bad_desc("e_zero", 64'h0, 64'h0);
    bad_desc("e_end_mis", 64'h1000, 64'h1008);
    bad_desc("e_rev", 64'h2000, 64'h1000);
    bad_desc("e_big", 64'h0, LIMIT + 64'h10);
    start = 1'b1; abort = 1'b1; start_addr = 64'h1000; end_addr = 64'h2000;
    step();
    clear_inputs();
    chk("abort_start_err", error, 1);
    chk("abort_start_busy", busy, 0);
    run_transfer(64'h1000, 64'h1400, 0, 500);

    // Backpressure held across ISSUE
    run_transfer(64'h7F00, 64'h9000, 2, 2000);
    run_transfer(64'h7F00, 64'h9000, 3, 2000);

    // Abort after 3 of 16 beats, then drain the remaining 13
    start = 1'b1; start_addr = 64'h3000; end_addr = 64'h3100;
    step();
    start = 1'b0;
    step();
    chk("ab_strobe", dram_read_en, 1);
    dram_read_data_valid = 1'b1;
    repeat (3) step();
    dram_read_data_valid = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_drain_busy", busy, 1);
    n = 0; guard = 0; saw = 0; busy_drop = 0;
    while (n < 13 && guard < 200) begin
      dram_read_data_valid = ($urandom_range(0, 1) == 1);
      if (dram_read_data_valid) n++;
      step();
      guard++;
      saw |= dram_read_en | done;
      if (n < 13 && !busy) busy_drop = 1;
    end
    dram_read_data_valid = 1'b0;
    chk("ab_busy_low", busy, 0);
    chk("ab_busy_hold", busy_drop, 0);
    repeat (4) begin
      dram_read_data_valid = 1'b1;
      step();
      saw |= dram_read_en | done | busy;
    end
    dram_read_data_valid = 1'b0;
    chk("ab_quiet", saw, 0);

    // Abort coinciding with the strobe condition in ISSUE
    start = 1'b1; start_addr = 64'h6000; end_addr = 64'h6200;
    step();
    start = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    saw = dram_read_en | done;
    chk("ai_busy", busy, 0);
    repeat (4) begin step(); saw |= dram_read_en | done | busy; end
    chk("ai_quiet", saw, 0);

    // Reset in the middle of WAIT_BEATS
    start = 1'b1; start_addr = 64'h5000; end_addr = 64'h5400;
    step();
    start = 1'b0;
    step();
    dram_read_data_valid = 1'b1;
    step();
    step();
    dram_read_data_valid = 1'b0;
    image_sender_reset = 1'b1;
    step();
    image_sender_reset = 1'b0;
    chk("rm_busy", busy, 0);
    chk("rm_addr", dram_read_addr, 0);
    chk("rm_len", dram_read_len, 0);
    chk("rm_en", dram_read_en, 0);
    chk("rm_done", done, 0);
    chk("rm_err", error, 0);
    step();
    run_transfer(64'h2_0F00, 64'h2_1500, 0, 500);

    // Random descriptors with stalls, gaps, stray beats and ignored starts
    for (int k = 0; k < 5; k++) begin
      nb = longint'($urandom_range(1, 300));
      s  = {32'($urandom), 32'($urandom)} & 64'h7F_FFFF_FFF0;
      e  = s + nb * 16;
      if (e > LIMIT) begin s = LIMIT - nb * 16; e = LIMIT; end
      run_transfer(s, e, 1, 5000);
    end
    run_transfer(LIMIT - 64'h1100, LIMIT, 1, 5000);

    // Long transfer: 256 full bursts
    run_transfer(64'h1000, 64'h10_1000, 0, 70000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
